udp_send: RTL and testbench
===========================

// Module: udp_send
// PURPOSE
//  Transmit counterpart of the UDP receive path: takes a raw application byte stream (AXI-Stream, 8 bit),
//  buffers one whole frame store-and-forward, prepends the 8-byte UDP header, and streams header+payload
//  to the IP transmit layer. Checksum is not computed; it is sent as 16'h0000 (legal for IPv4).
// PARAMETERS
//  DEPTH_LOG2   11   payload buffer = 2**DEPTH_LOG2 bytes = max payload per frame (MAXP)
// PORTS
//  clk                  in   1   single clock
//  reset                in   1   synchronous, active-high
//  src_port_in          in   16  UDP source port, sampled on first accepted payload byte
//  dest_port_in         in   16  UDP dest port, sampled on first accepted payload byte
//  udpdata_tdata_in     in   8   application payload byte
//  udpdata_tvalid_in    in   1   payload valid
//  udpdata_tlast_in     in   1   last payload byte of frame
//  udpdata_tready_out   out  1   high only in FILL
//  udp_axis_tdata_out   out  8   header/payload byte to IP layer
//  udp_axis_tvalid_out  out  1   output valid
//  udp_axis_tlast_out   out  1   last byte of UDP datagram
//  udp_axis_tready_in   in   1   IP layer ready
//  udp_len_out          out  16  UDP length (8 + payload bytes), stable from HDR entry to end of frame
//  udp_len_valid_out    out  1   high from HDR entry until last output handshake
//  drop_out             out  1   1-cycle pulse: oversize frame discarded
// BEHAVIOUR
//  - Reset: all outputs 0, state FILL, pointers/counters 0; buffer contents don't care.
//  - States: FILL -> HDR -> DATA -> FILL; DROP (sub-mode of FILL via ovf flag).
//  - FILL: tready_out=1. Each in-handshake writes buf[cnt], cnt++. First byte of frame latches ports.
//    tlast with cnt+1<=MAXP: len = cnt+1+8 (16-bit), -> HDR next cycle; tready_out low from that cycle.
//    Byte arriving when cnt==MAXP: set ovf, discard it and all bytes to tlast; on tlast pulse drop_out,
//    clear cnt/ovf, stay FILL. A frame of exactly MAXP bytes is sent, not dropped.
//  - HDR: emit 8 bytes MSB first: src[15:8],src[7:0],dst[15:8],dst[7:0],len[15:8],len[7:0],8'h00,8'h00.
//    Byte index advances only on tvalid_out&&tready_in. tvalid_out first asserted 1 cycle after tlast in.
//  - DATA: emit buf[0..cnt-1]; tlast_out on final byte only. Throughput 1 byte/cycle with tready_in
//    held high, no bubble between header byte 7 and payload byte 0 nor between payload bytes
//    (buffer read is registered: prefetch during HDR; hold data via 1-entry skid when tready_in low).
//  - AXIS rules: once tvalid_out=1, tdata/tlast hold until handshake; tvalid_out never drops before it.
//  - After final handshake: tvalid_out=0, udp_len_valid_out=0, FILL next cycle, tready_out=1.
//  - Input tvalid while not in FILL is ignored (tready_out=0). No overlap of fill and send.
//  - Mid-operation reset: frame abandoned, no tlast emitted, outputs to reset values next cycle.
//  - Width: cnt is DEPTH_LOG2+1 bits; len arithmetic 16-bit, DEPTH_LOG2 <= 15 enforced by assertion.
// STRUCTURE
//  - udp_pkg: UDP_HDR_BYTES=8, UDP_CSUM_NONE=16'h0000, state encodings FILL/HDR/DATA.
//  - Sub-module udp_tx_buf: simple dual-port byte RAM, 1 write / 1 registered read port, DEPTH_LOG2 param.
//  - Top: FSM, counters, header mux, output skid register.
// TESTING
//  1 src=0x1234,dst=0x5678, payload 01..04, tready_in=1 -> 12,34,56,78,00,0C,00,00,01,02,03,04; tlast on 04.
//  2 Same frame, tready_in toggling 1/0 each cycle -> identical byte sequence, data stable while stalled.
//  3 1-byte payload 0xAB -> len 0x0009, 9 bytes out, tlast on 0xAB; udp_len_out=9 throughout.
//  4 DEPTH_LOG2=4: 16-byte frame -> sent, len 0x0018; 17-byte frame -> drop_out pulse, nothing sent,
//    next 2-byte frame sent correctly.
//  5 Back-to-back frames at input -> tready_out low during HDR/DATA, second frame sent intact after first.
//  6 reset asserted at DATA byte 3 -> tvalid_out=0 next cycle, no tlast; next frame sent correctly.

Source files
------------

// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared constants, state encoding and header byte mux for the UDP transmit path
package udp_pkg;

    localparam int          UDP_HDR_BYTES = 8;
    localparam logic [15:0] UDP_CSUM_NONE = 16'h0000;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } udp_state_t;

    // Header bytes in wire order: ports, length, then the unused checksum.
    function automatic logic [7:0] udp_hdr_byte(input logic [15:0] src,
                                                input logic [15:0] dst,
                                                input logic [15:0] len,
                                                input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = src[15:8];
            3'd1:    b = src[7:0];
            3'd2:    b = dst[15:8];
            3'd3:    b = dst[7:0];
            3'd4:    b = len[15:8];
            3'd5:    b = len[7:0];
            3'd6:    b = UDP_CSUM_NONE[15:8];
            default: b = UDP_CSUM_NONE[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/udp_tx_buf.sv
// rtl/udp_tx_buf.sv - simple dual-port payload byte RAM, one write port and one registered read port
module udp_tx_buf #(
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/udp_send.sv
// rtl/udp_send.sv - store-and-forward UDP transmit: buffers a payload frame, then sends header + payload
module udp_send
    import udp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] src_port_in,
    input  logic [15:0] dest_port_in,
    input  logic [7:0]  udpdata_tdata_in,
    input  logic        udpdata_tvalid_in,
    input  logic        udpdata_tlast_in,
    output logic        udpdata_tready_out,
    output logic [7:0]  udp_axis_tdata_out,
    output logic        udp_axis_tvalid_out,
    output logic        udp_axis_tlast_out,
    input  logic        udp_axis_tready_in,
    output logic [15:0] udp_len_out,
    output logic        udp_len_valid_out,
    output logic        drop_out
);

    localparam int             CW   = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]  MAXP = CW'(1) << DEPTH_LOG2;

    udp_state_t            state, state_n;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         rd_ptr;
    logic [2:0]            hdr_idx;
    logic                  ovf;
    logic [15:0]           len_q;
    logic [15:0]           src_q;
    logic [15:0]           dst_q;
    logic                  drop_q;
    logic [7:0]            rd_data;
    logic [DEPTH_LOG2-1:0] rd_addr;

    logic in_hs, out_hs, full, last_byte, wr_en;

    assign in_hs     = udpdata_tvalid_in && udpdata_tready_out;
    assign out_hs    = udp_axis_tvalid_out && udp_axis_tready_in;
    assign full      = ovf || (cnt == MAXP);
    assign last_byte = (state == ST_DATA) && (rd_ptr == cnt - CW'(1));
    assign wr_en     = in_hs && !full;

    // The read address looks one byte ahead on a handshake, so the registered RAM output
    // always holds buf[rd_ptr]: it doubles as the hold register while the IP layer stalls.
    udp_tx_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (cnt[DEPTH_LOG2-1:0]),
        .wr_data (udpdata_tdata_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FILL;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n             = state;
        udpdata_tready_out  = (state == ST_FILL) && !reset;
        udp_axis_tvalid_out = 1'b0;
        udp_axis_tdata_out  = 8'h00;
        udp_axis_tlast_out  = 1'b0;
        rd_addr             = rd_ptr[DEPTH_LOG2-1:0];
        case (state)
            ST_FILL: begin
                if (in_hs && udpdata_tlast_in && !full) begin
                    state_n = ST_HDR;
                end
            end
            ST_HDR: begin
                udp_axis_tvalid_out = 1'b1;
                udp_axis_tdata_out  = udp_hdr_byte(src_q, dst_q, len_q, hdr_idx);
                if (out_hs && hdr_idx == 3'd7) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                udp_axis_tvalid_out = 1'b1;
                udp_axis_tdata_out  = rd_data;
                udp_axis_tlast_out  = last_byte;
                if (out_hs) begin
                    rd_addr = rd_ptr[DEPTH_LOG2-1:0] + DEPTH_LOG2'(1);
                    if (last_byte) begin
                        state_n = ST_FILL;
                    end
                end
            end
            default: state_n = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            rd_ptr  <= '0;
            hdr_idx <= 3'd0;
            ovf     <= 1'b0;
            len_q   <= 16'h0000;
            src_q   <= 16'h0000;
            dst_q   <= 16'h0000;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (in_hs) begin
                if (full) begin
                    if (udpdata_tlast_in) begin
                        drop_q <= 1'b1;
                        cnt    <= '0;
                        ovf    <= 1'b0;
                    end else begin
                        ovf <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                    if (cnt == '0) begin
                        src_q <= src_port_in;
                        dst_q <= dest_port_in;
                    end
                    if (udpdata_tlast_in) begin
                        len_q <= 16'(cnt) + 16'(UDP_HDR_BYTES + 1);
                    end
                end
            end
            // hdr_idx wraps 7 -> 0 on its own, ready for the next frame.
            if (out_hs) begin
                if (state == ST_HDR) begin
                    hdr_idx <= hdr_idx + 3'd1;
                end else if (last_byte) begin
                    cnt    <= '0;
                    rd_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + CW'(1);
                end
            end
        end
    end

    assign udp_len_out       = len_q;
    assign udp_len_valid_out = udp_axis_tvalid_out;
    assign drop_out          = drop_q;

    a_depth_fits_len: assert property (@(posedge clk) DEPTH_LOG2 <= 15);

endmodule

// File: tb/tb_udp_send.sv
// tb/tb_udp_send.sv - directed scoreboard bench for udp_send with a 16-byte payload buffer
module tb_udp_send;

    localparam int DL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] src_port_in, dest_port_in;
    logic [7:0]  udpdata_tdata_in;
    logic        udpdata_tvalid_in, udpdata_tlast_in, udpdata_tready_out;
    logic [7:0]  udp_axis_tdata_out;
    logic        udp_axis_tvalid_out, udp_axis_tlast_out, udp_axis_tready_in;
    logic [15:0] udp_len_out;
    logic        udp_len_valid_out, drop_out;

    udp_send #(.DEPTH_LOG2(DL)) dut (
        .clk                 (clk),
        .reset               (reset),
        .src_port_in         (src_port_in),
        .dest_port_in        (dest_port_in),
        .udpdata_tdata_in    (udpdata_tdata_in),
        .udpdata_tvalid_in   (udpdata_tvalid_in),
        .udpdata_tlast_in    (udpdata_tlast_in),
        .udpdata_tready_out  (udpdata_tready_out),
        .udp_axis_tdata_out  (udp_axis_tdata_out),
        .udp_axis_tvalid_out (udp_axis_tvalid_out),
        .udp_axis_tlast_out  (udp_axis_tlast_out),
        .udp_axis_tready_in  (udp_axis_tready_in),
        .udp_len_out         (udp_len_out),
        .udp_len_valid_out   (udp_len_valid_out),
        .drop_out            (drop_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [7:0]  data;
        logic [15:0] len;
    } exp_t;

    typedef struct packed {
        logic        last;
        logic [7:0]  data;
        logic [15:0] src;
        logic [15:0] dst;
    } in_t;

    exp_t exp_q[$];
    in_t  in_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   hs_count = 0;
    int   drops    = 0;
    bit   toggle   = 0;
    bit   prev_stall = 0;
    bit   after_last = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] src, input logic [15:0] dst, input int n,
                              input logic [7:0] base, input bit sent);
        logic [15:0] len;
        logic [7:0]  hb [8];
        len = 16'(n + 8);
        hb  = '{src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], 8'h00, 8'h00};
        if (sent) begin
            for (int i = 0; i < 8; i++) exp_q.push_back('{last: 1'b0, data: hb[i], len: len});
            for (int i = 0; i < n; i++)
                exp_q.push_back('{last: (i == n - 1), data: base + 8'(i), len: len});
        end
        for (int i = 0; i < n; i++)
            in_q.push_back('{last: (i == n - 1), data: base + 8'(i), src: src, dst: dst});
    endtask

    task automatic run(input int max_cycles, input int stop_hs);
        int idle;
        bit acc;
        bit done;
        idle = 0;
        done = 0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            if (in_q.size() > 0) begin
                udpdata_tvalid_in = 1'b1;
                udpdata_tdata_in  = in_q[0].data;
                udpdata_tlast_in  = in_q[0].last;
                src_port_in       = in_q[0].src;
                dest_port_in      = in_q[0].dst;
            end else begin
                udpdata_tvalid_in = 1'b0;
                udpdata_tlast_in  = 1'b0;
            end
            udp_axis_tready_in = toggle ? ~udp_axis_tready_in : 1'b1;
            @(negedge clk);
            acc = udpdata_tvalid_in && udpdata_tready_out;
            @(posedge clk);
            #1;
            if (acc) void'(in_q.pop_front());
            if (in_q.size() == 0 && exp_q.size() == 0) idle++;
            else idle = 0;
            if ((stop_hs > 0 && hs_count >= stop_hs) || idle >= 4) done = 1;
        end
        check("run_done", 32'(done), 32'(1));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
            after_last = 0;
        end else begin
            if (drop_out) drops++;
            if (after_last) begin
                check("idle_tvalid", 32'(udp_axis_tvalid_out), 32'(0));
                check("idle_len_valid", 32'(udp_len_valid_out), 32'(0));
                check("idle_tready", 32'(udpdata_tready_out), 32'(1));
                after_last = 0;
            end
            if (prev_stall) begin
                check("stall_tvalid", 32'(udp_axis_tvalid_out), 32'(1));
                check("stall_tdata", 32'(udp_axis_tdata_out), 32'(prev_data));
                check("stall_tlast", 32'(udp_axis_tlast_out), 32'(prev_last));
            end
            if (udp_axis_tvalid_out) begin
                check("in_tready_low", 32'(udpdata_tready_out), 32'(0));
                check("len_valid", 32'(udp_len_valid_out), 32'(1));
            end
            if (udp_axis_tvalid_out && udp_axis_tready_in) begin
                check("exp_avail", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tdata", 32'(udp_axis_tdata_out), 32'(e.data));
                    check("tlast", 32'(udp_axis_tlast_out), 32'(e.last));
                    check("udp_len", 32'(udp_len_out), 32'(e.len));
                end
                hs_count++;
                if (udp_axis_tlast_out) after_last = 1;
            end
            prev_stall = udp_axis_tvalid_out && !udp_axis_tready_in;
            prev_data  = udp_axis_tdata_out;
            prev_last  = udp_axis_tlast_out;
        end
    end

    initial begin
        reset = 1'b1;
        src_port_in = 16'h0; dest_port_in = 16'h0;
        udpdata_tdata_in = 8'h0; udpdata_tvalid_in = 1'b0; udpdata_tlast_in = 1'b0;
        udp_axis_tready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_tvalid", 32'(udp_axis_tvalid_out), 32'(0));
        check("rst_tlast", 32'(udp_axis_tlast_out), 32'(0));
        check("rst_tdata", 32'(udp_axis_tdata_out), 32'(0));
        check("rst_len", 32'(udp_len_out), 32'(0));
        check("rst_len_valid", 32'(udp_len_valid_out), 32'(0));
        check("rst_drop", 32'(drop_out), 32'(0));
        check("rst_tready", 32'(udpdata_tready_out), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_tready", 32'(udpdata_tready_out), 32'(1));
        @(posedge clk); #1;

        // 1: basic 4-byte frame
        push_frame(16'h1234, 16'h5678, 4, 8'h01, 1);
        run(200, 0);

        // 2: same frame with the IP layer stalling every other cycle
        toggle = 1;
        push_frame(16'h1234, 16'h5678, 4, 8'h01, 1);
        run(300, 0);
        toggle = 0;

        // 3: single-byte payload
        push_frame(16'hBEEF, 16'h0035, 1, 8'hAB, 1);
        run(200, 0);

        // 4: exactly full buffer, two oversize frames, then a small one
        drops = 0;
        push_frame(16'h1111, 16'h2222, 16, 8'h40, 1);
        push_frame(16'h3333, 16'h4444, 17, 8'h80, 0);
        push_frame(16'h5555, 16'h6666, 20, 8'hA0, 0);
        push_frame(16'h7777, 16'h8888, 2, 8'hC0, 1);
        run(600, 0);
        check("drop_count", 32'(drops), 32'(2));

        // 5: back-to-back input frames
        push_frame(16'h0A0B, 16'h0C0D, 5, 8'h10, 1);
        push_frame(16'h0E0F, 16'h1011, 3, 8'h20, 1);
        run(400, 0);

        // 6: reset while payload byte 3 is on the bus
        hs_count = 0;
        push_frame(16'h4242, 16'h2424, 6, 8'h30, 1);
        run(300, 11);
        check("pre_rst_byte3", 32'(udp_axis_tdata_out), 32'(8'h33));
        udp_axis_tready_in = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        in_q.delete();
        udpdata_tvalid_in = 1'b0;
        udpdata_tlast_in  = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", 32'(udp_axis_tvalid_out), 32'(0));
        check("midrst_tlast", 32'(udp_axis_tlast_out), 32'(0));
        check("midrst_len_valid", 32'(udp_len_valid_out), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        push_frame(16'h9999, 16'hAAAA, 3, 8'h50, 1);
        run(200, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
